// File: rtl/sd_card_block_xfer.sv
// SD-bus block-transfer sequencer: issues CMD17/18/24/25, drives the data-path
// handshakes, closes multi-block transfers with CMD12 and retries from the failing block.
module sd_card_block_xfer #(
    parameter int          TIMEOUT_W = 8,
    parameter int          CNT_W     = 32,
    parameter int          MAX_RETRY = 2,
    parameter logic [31:0] ERR_MASK  = 32'hFFF8_0000,
    parameter logic [31:0] STOP_ARG  = 32'hAAAA_AAAA,
    localparam int         RC_W      = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Xfer_Enable,
    input  logic             Write_Mode,
    input  logic [31:0]      SD_Addr_Block,
    input  logic [CNT_W-1:0] SerialCount,
    input  logic [47:0]      Responce_R1_R3,
    output logic [5:0]       CMD_ID,
    output logic [31:0]      CMD_Arg,
    output logic             Send_CMD_En,
    input  logic             Send_CMD_Complite,
    output logic             Get_CMD_En,
    input  logic             Get_CMD_Complite,
    output logic             Get_DATA_En,
    input  logic             Get_DATA_Complite,
    input  logic             Get_DATA_CRC_Fail,
    output logic             Put_DATA_En,
    input  logic             Put_DATA_Complite,
    input  logic             Put_DATA_CRC_Fail,
    output logic [CNT_W-1:0] BlockCount,
    output logic [RC_W-1:0]  Retry_Count,
    output logic             Xfer_complite,
    output logic             Xfer_Fail
);

    typedef enum logic [3:0] {
        IDLE, SEND_CMD, GET_RESP, DATA, NEXT_BLK,
        SEND_STOP, GET_STOP_RESP, RETRY, FAIL, DONE
    } state_t;

    state_t               state_q, state_d;
    logic [5:0]           cmd_id_q, cmd_id_d;
    logic [31:0]          cmd_arg_q, cmd_arg_d;
    logic                 send_cmd_en_q, send_cmd_en_d;
    logic                 get_cmd_en_q, get_cmd_en_d;
    logic                 get_data_en_q, get_data_en_d;
    logic                 put_data_en_q, put_data_en_d;
    logic [CNT_W-1:0]     block_count_q, block_count_d;
    logic [RC_W-1:0]      retry_count_q, retry_count_d;
    logic                 complite_q, complite_d;
    logic                 fail_q, fail_d;
    logic                 mode_q, mode_d;
    logic                 multi_q, multi_d;
    logic                 stop_err_q, stop_err_d;
    logic [CNT_W-1:0]     serial_q, serial_d;
    logic [31:0]          addr_q, addr_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;

    logic [31:0] status;
    logic        resp_err, timer_done, data_done, data_crc;
    logic        raise_err, start_stop, retry_multi;
    logic        resp_unused;

    function automatic logic [5:0] cmd_index(input logic wr, input logic multi);
        case ({wr, multi})
            2'b00:   return 6'd17;
            2'b01:   return 6'd18;
            2'b10:   return 6'd24;
            default: return 6'd25;
        endcase
    endfunction

    assign status      = Responce_R1_R3[39:8];
    assign resp_unused = ^{Responce_R1_R3[47:40], Responce_R1_R3[7:0]};
    assign resp_err    = |(status & ERR_MASK);
    assign timer_done  = &timer_q;
    assign data_done   = mode_q ? Put_DATA_Complite : Get_DATA_Complite;
    assign data_crc    = mode_q ? Put_DATA_CRC_Fail : Get_DATA_CRC_Fail;
    // A retry restarts at the failed block, so only the remaining blocks decide multi.
    assign retry_multi = (serial_q != block_count_q);

    always_comb begin
        state_d       = state_q;
        cmd_id_d      = cmd_id_q;
        cmd_arg_d     = cmd_arg_q;
        send_cmd_en_d = send_cmd_en_q;
        get_cmd_en_d  = get_cmd_en_q;
        get_data_en_d = get_data_en_q;
        put_data_en_d = put_data_en_q;
        block_count_d = block_count_q;
        retry_count_d = retry_count_q;
        complite_d    = complite_q;
        fail_d        = fail_q;
        mode_d        = mode_q;
        multi_d       = multi_q;
        stop_err_d    = stop_err_q;
        serial_d      = serial_q;
        addr_d        = addr_q;
        timer_d       = timer_q;
        raise_err     = 1'b0;
        start_stop    = 1'b0;

        case (state_q)
            IDLE: begin
                if (Xfer_Enable) begin
                    mode_d        = Write_Mode;
                    multi_d       = (SerialCount != '0);
                    serial_d      = SerialCount;
                    addr_d        = SD_Addr_Block;
                    block_count_d = '0;
                    retry_count_d = '0;
                    cmd_id_d      = cmd_index(Write_Mode, SerialCount != '0);
                    cmd_arg_d     = SD_Addr_Block;
                    send_cmd_en_d = 1'b1;
                    state_d       = SEND_CMD;
                end
            end
            SEND_CMD: begin
                if (Send_CMD_Complite) begin
                    send_cmd_en_d = 1'b0;
                    get_cmd_en_d  = 1'b1;
                    get_data_en_d = ~mode_q;
                    timer_d       = '0;
                    state_d       = GET_RESP;
                end
            end
            GET_RESP: begin
                if (Get_CMD_Complite) begin
                    get_cmd_en_d = 1'b0;
                    timer_d      = '0;
                    if (resp_err) begin
                        raise_err = 1'b1;
                    end else begin
                        put_data_en_d = mode_q;
                        state_d       = DATA;
                    end
                end else if (timer_done) begin
                    raise_err = 1'b1;
                end else begin
                    timer_d = timer_q + TIMEOUT_W'(1);
                end
            end
            DATA: begin
                if (data_done) begin
                    get_data_en_d = 1'b0;
                    put_data_en_d = 1'b0;
                    if (data_crc) begin
                        raise_err = 1'b1;
                    end else begin
                        block_count_d = block_count_q + CNT_W'(1);
                        if (block_count_q == serial_q) begin
                            if (multi_q) begin
                                start_stop = 1'b1;
                                stop_err_d = 1'b0;
                            end else begin
                                complite_d = 1'b1;
                                state_d    = DONE;
                            end
                        end else begin
                            state_d = NEXT_BLK;
                        end
                    end
                end
            end
            NEXT_BLK: begin
                get_data_en_d = ~mode_q;
                put_data_en_d = mode_q;
                state_d       = DATA;
            end
            SEND_STOP: begin
                if (Send_CMD_Complite) begin
                    send_cmd_en_d = 1'b0;
                    get_cmd_en_d  = 1'b1;
                    timer_d       = '0;
                    state_d       = GET_STOP_RESP;
                end
            end
            GET_STOP_RESP: begin
                if (Get_CMD_Complite) begin
                    get_cmd_en_d = 1'b0;
                    timer_d      = '0;
                    if (resp_err) begin
                        fail_d  = 1'b1;
                        state_d = FAIL;
                    end else if (stop_err_q) begin
                        state_d = RETRY;
                    end else begin
                        complite_d = 1'b1;
                        state_d    = DONE;
                    end
                end else if (timer_done) begin
                    get_cmd_en_d = 1'b0;
                    fail_d       = 1'b1;
                    state_d      = FAIL;
                end else begin
                    timer_d = timer_q + TIMEOUT_W'(1);
                end
            end
            RETRY: begin
                if (retry_count_q == RC_W'(MAX_RETRY)) begin
                    fail_d  = 1'b1;
                    state_d = FAIL;
                end else begin
                    retry_count_d = retry_count_q + RC_W'(1);
                    multi_d       = retry_multi;
                    cmd_id_d      = cmd_index(mode_q, retry_multi);
                    cmd_arg_d     = addr_q + 32'(block_count_q);
                    send_cmd_en_d = 1'b1;
                    state_d       = SEND_CMD;
                end
            end
            DONE: begin
                if (!Xfer_Enable) begin
                    complite_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            FAIL: begin
                if (!Xfer_Enable) begin
                    fail_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An accepted multi-block command must be closed with CMD12 before retrying.
        if (raise_err) begin
            send_cmd_en_d = 1'b0;
            get_cmd_en_d  = 1'b0;
            get_data_en_d = 1'b0;
            put_data_en_d = 1'b0;
            if (multi_q) begin
                start_stop = 1'b1;
                stop_err_d = 1'b1;
            end else begin
                state_d = RETRY;
            end
        end

        if (start_stop) begin
            cmd_id_d      = 6'd12;
            cmd_arg_d     = STOP_ARG;
            send_cmd_en_d = 1'b1;
            state_d       = SEND_STOP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cmd_id_q      <= '0;
            cmd_arg_q     <= '0;
            send_cmd_en_q <= 1'b0;
            get_cmd_en_q  <= 1'b0;
            get_data_en_q <= 1'b0;
            put_data_en_q <= 1'b0;
            block_count_q <= '0;
            retry_count_q <= '0;
            complite_q    <= 1'b0;
            fail_q        <= 1'b0;
            mode_q        <= 1'b0;
            multi_q       <= 1'b0;
            stop_err_q    <= 1'b0;
            serial_q      <= '0;
            addr_q        <= '0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            cmd_id_q      <= cmd_id_d;
            cmd_arg_q     <= cmd_arg_d;
            send_cmd_en_q <= send_cmd_en_d;
            get_cmd_en_q  <= get_cmd_en_d;
            get_data_en_q <= get_data_en_d;
            put_data_en_q <= put_data_en_d;
            block_count_q <= block_count_d;
            retry_count_q <= retry_count_d;
            complite_q    <= complite_d;
            fail_q        <= fail_d;
            mode_q        <= mode_d;
            multi_q       <= multi_d;
            stop_err_q    <= stop_err_d;
            serial_q      <= serial_d;
            addr_q        <= addr_d;
            timer_q       <= timer_d;
        end
    end

    assign CMD_ID        = cmd_id_q;
    assign CMD_Arg       = cmd_arg_q;
    assign Send_CMD_En   = send_cmd_en_q;
    assign Get_CMD_En    = get_cmd_en_q;
    assign Get_DATA_En   = get_data_en_q;
    assign Put_DATA_En   = put_data_en_q;
    assign BlockCount    = block_count_q;
    assign Retry_Count   = retry_count_q;
    assign Xfer_complite = complite_q;
    assign Xfer_Fail     = fail_q;

endmodule

// File: tb/tb_sd_card_block_xfer.sv
// Bench for sd_card_block_xfer: a reactive card/engine responder driven by fault plans,
// checked against a transaction-level model of the command sequence and final counts.
module tb_sd_card_block_xfer;

    localparam int          TIMEOUT_W = 8;
    localparam int          CNT_W     = 32;
    localparam int          MAX_RETRY = 2;
    localparam logic [31:0] ERR_MASK  = 32'hFFF8_0000;
    localparam logic [31:0] STOP_ARG  = 32'hAAAA_AAAA;
    localparam int          RC_W      = 2;
    localparam int          BUDGET    = 4000;

    logic             clk = 1'b0;
    logic             rst;
    logic             Xfer_Enable, Write_Mode;
    logic [31:0]      SD_Addr_Block;
    logic [CNT_W-1:0] SerialCount;
    logic [47:0]      Responce_R1_R3;
    logic [5:0]       CMD_ID;
    logic [31:0]      CMD_Arg;
    logic             Send_CMD_En, Send_CMD_Complite;
    logic             Get_CMD_En, Get_CMD_Complite;
    logic             Get_DATA_En, Get_DATA_Complite, Get_DATA_CRC_Fail;
    logic             Put_DATA_En, Put_DATA_Complite, Put_DATA_CRC_Fail;
    logic [CNT_W-1:0] BlockCount;
    logic [RC_W-1:0]  Retry_Count;
    logic             Xfer_complite, Xfer_Fail;

    always #5 clk = ~clk;

    sd_card_block_xfer #(
        .TIMEOUT_W(TIMEOUT_W), .CNT_W(CNT_W), .MAX_RETRY(MAX_RETRY),
        .ERR_MASK(ERR_MASK), .STOP_ARG(STOP_ARG)
    ) dut (
        .clk(clk), .rst(rst), .Xfer_Enable(Xfer_Enable), .Write_Mode(Write_Mode),
        .SD_Addr_Block(SD_Addr_Block), .SerialCount(SerialCount),
        .Responce_R1_R3(Responce_R1_R3), .CMD_ID(CMD_ID), .CMD_Arg(CMD_Arg),
        .Send_CMD_En(Send_CMD_En), .Send_CMD_Complite(Send_CMD_Complite),
        .Get_CMD_En(Get_CMD_En), .Get_CMD_Complite(Get_CMD_Complite),
        .Get_DATA_En(Get_DATA_En), .Get_DATA_Complite(Get_DATA_Complite),
        .Get_DATA_CRC_Fail(Get_DATA_CRC_Fail), .Put_DATA_En(Put_DATA_En),
        .Put_DATA_Complite(Put_DATA_Complite), .Put_DATA_CRC_Fail(Put_DATA_CRC_Fail),
        .BlockCount(BlockCount), .Retry_Count(Retry_Count),
        .Xfer_complite(Xfer_complite), .Xfer_Fail(Xfer_Fail)
    );

    int checks = 0;
    int failures = 0;

    // Fault plans: resp 0=ok 1=random status error 2=no response 3=status bit 31; crc/stop likewise.
    int plan_resp[$];
    int plan_crc[$];
    int plan_stop[$];
    int ri, ci, si;

    logic [5:0]  obs_id[$];
    logic [31:0] obs_arg[$];
    logic [5:0]  exp_id[$];
    logic [31:0] exp_arg[$];
    longint      exp_bc;
    int          exp_retry;
    bit          exp_ok;

    bit         cmd_seen, resp_decided, resp_delivered, resp_ok, data_busy, data_crc, tmo_active;
    int         send_wait, resp_wait, data_wait, fault, tmo_len;
    logic [5:0] last_cmd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] make_resp(input int f);
        logic [31:0] st;
        st = $urandom & ~ERR_MASK;
        if (f == 1) st[$urandom_range(19, 31)] = 1'b1;
        if (f == 3) st[31] = 1'b1;
        return {8'($urandom), st, 8'($urandom)};
    endfunction

    task automatic clear_plans();
        plan_resp.delete();
        plan_crc.delete();
        plan_stop.delete();
    endtask

    // Expected command list and final counts from the transfer rules, one attempt at a time.
    task automatic run_model(input bit w, input logic [31:0] addr, input logic [31:0] serial);
        longint total, bc;
        int     mri, mci, msi, retries, f;
        bit     multi, failed, fin;
        total = longint'(serial) + 1;
        bc = 0; mri = 0; mci = 0; msi = 0; retries = 0; fin = 0;
        exp_id.delete(); exp_arg.delete(); exp_ok = 0;
        while (!fin) begin
            multi = (total - bc) > 1;
            exp_id.push_back(w ? (multi ? 6'd25 : 6'd24) : (multi ? 6'd18 : 6'd17));
            exp_arg.push_back(addr + 32'(bc));
            f = (mri < plan_resp.size()) ? plan_resp[mri] : 0;
            mri++;
            failed = (f != 0);
            while (!failed && bc < total) begin
                if (mci < plan_crc.size() && plan_crc[mci] != 0) failed = 1;
                else bc++;
                mci++;
            end
            if (multi) begin
                exp_id.push_back(6'd12);
                exp_arg.push_back(STOP_ARG);
                f = (msi < plan_stop.size()) ? plan_stop[msi] : 0;
                msi++;
                if (f != 0) fin = 1;
            end
            if (!fin) begin
                if (!failed) begin
                    exp_ok = 1;
                    fin = 1;
                end else if (retries == MAX_RETRY) begin
                    fin = 1;
                end else begin
                    retries++;
                end
            end
        end
        exp_bc = bc;
        exp_retry = retries;
    endtask

    // One clock of the card/engine responder, acting at the falling edge.
    task automatic step();
        @(negedge clk);
        Send_CMD_Complite = 0; Get_CMD_Complite = 0;
        Get_DATA_Complite = 0; Put_DATA_Complite = 0;
        Get_DATA_CRC_Fail = 0; Put_DATA_CRC_Fail = 0;

        if ((Get_DATA_En || Put_DATA_En) && resp_ok && last_cmd != 6'd12) begin
            if (!data_busy) begin
                data_busy = 1;
                data_wait = $urandom_range(0, 3);
                data_crc  = (ci < plan_crc.size()) ? (plan_crc[ci] != 0) : 1'b0;
                ci++;
            end
            if (data_wait == 0) begin
                if (Get_DATA_En) begin
                    Get_DATA_Complite = 1; Get_DATA_CRC_Fail = data_crc;
                end else begin
                    Put_DATA_Complite = 1; Put_DATA_CRC_Fail = data_crc;
                end
                data_busy = 0;
            end else begin
                data_wait--;
            end
        end

        if (tmo_active && !Get_CMD_En) begin
            check("timeout_window", 64'(tmo_len), 64'(256));
            tmo_active = 0;
        end

        if (Send_CMD_En) begin
            if (!cmd_seen) begin
                cmd_seen = 1;
                obs_id.push_back(CMD_ID);
                obs_arg.push_back(CMD_Arg);
                last_cmd = CMD_ID;
                send_wait = $urandom_range(0, 3);
                resp_decided = 0; resp_delivered = 0; resp_ok = 0; data_busy = 0;
            end
            if (send_wait == 0) begin
                Send_CMD_Complite = 1;
                cmd_seen = 0;
            end else begin
                send_wait--;
            end
        end

        if (Get_CMD_En && !resp_delivered) begin
            if (!resp_decided) begin
                resp_decided = 1;
                if (last_cmd == 6'd12) begin
                    fault = (si < plan_stop.size()) ? plan_stop[si] : 0;
                    si++;
                end else begin
                    fault = (ri < plan_resp.size()) ? plan_resp[ri] : 0;
                    ri++;
                end
                resp_wait = $urandom_range(0, 4);
                if (fault == 2) begin
                    tmo_active = 1;
                    tmo_len = 0;
                end
            end
            if (fault == 2) begin
                tmo_len++;
            end else if (resp_wait == 0) begin
                Responce_R1_R3 = make_resp(fault);
                Get_CMD_Complite = 1;
                resp_delivered = 1;
                resp_ok = (fault == 0);
            end else begin
                resp_wait--;
            end
        end
    endtask

    task automatic start_xfer(input bit w, input logic [31:0] addr, input logic [31:0] serial);
        ri = 0; ci = 0; si = 0;
        obs_id.delete(); obs_arg.delete();
        cmd_seen = 0; resp_decided = 0; resp_delivered = 0; resp_ok = 0;
        data_busy = 0; tmo_active = 0; last_cmd = '0;
        run_model(w, addr, serial);
        Write_Mode = w;
        SD_Addr_Block = addr;
        SerialCount = serial;
        Xfer_Enable = 1;
    endtask

    task automatic finish_xfer(input string tag);
        int n;
        int m;
        n = 0;
        while (!(Xfer_complite || Xfer_Fail) && n < BUDGET) begin
            step();
            n++;
            if (n == 1) begin
                Write_Mode = 1'($urandom);
                SD_Addr_Block = $urandom;
                SerialCount = $urandom_range(0, 7);
            end
        end
        check({tag, "_in_budget"}, 64'(n < BUDGET), 64'(1));
        check({tag, "_complite"}, 64'(Xfer_complite), 64'(exp_ok));
        check({tag, "_fail"}, 64'(Xfer_Fail), 64'(!exp_ok));
        check({tag, "_block_count"}, 64'(BlockCount), 64'(exp_bc));
        check({tag, "_retry_count"}, 64'(Retry_Count), 64'(exp_retry));
        check({tag, "_num_cmds"}, 64'(obs_id.size()), 64'(exp_id.size()));
        m = (obs_id.size() < exp_id.size()) ? obs_id.size() : exp_id.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_cmd%0d_id", tag, i), 64'(obs_id[i]), 64'(exp_id[i]));
            check($sformatf("%s_cmd%0d_arg", tag, i), 64'(obs_arg[i]), 64'(exp_arg[i]));
        end
        step();
        step();
        check({tag, "_flag_held"}, 64'({Xfer_complite, Xfer_Fail}), 64'({exp_ok, !exp_ok}));
        Xfer_Enable = 0;
        step();
        check({tag, "_flags_clear"}, 64'({Xfer_complite, Xfer_Fail}), 64'(0));
        step();
        check({tag, "_idle_quiet"},
              64'({Send_CMD_En, Get_CMD_En, Get_DATA_En, Put_DATA_En}), 64'(0));
    endtask

    initial begin
        int n;
        int r;
        rst = 1; Xfer_Enable = 0; Write_Mode = 0; SD_Addr_Block = '0; SerialCount = '0;
        Responce_R1_R3 = '0;
        Send_CMD_Complite = 0; Get_CMD_Complite = 0;
        Get_DATA_Complite = 0; Get_DATA_CRC_Fail = 0;
        Put_DATA_Complite = 0; Put_DATA_CRC_Fail = 0;
        cmd_seen = 0; resp_decided = 0; resp_delivered = 0; resp_ok = 0;
        data_busy = 0; tmo_active = 0; last_cmd = '0;
        repeat (3) step();
        check("rst_cmd_id", 64'(CMD_ID), 64'(0));
        check("rst_cmd_arg", 64'(CMD_Arg), 64'(0));
        check("rst_send_en", 64'(Send_CMD_En), 64'(0));
        check("rst_get_cmd_en", 64'(Get_CMD_En), 64'(0));
        check("rst_get_data_en", 64'(Get_DATA_En), 64'(0));
        check("rst_put_data_en", 64'(Put_DATA_En), 64'(0));
        check("rst_block_count", 64'(BlockCount), 64'(0));
        check("rst_retry_count", 64'(Retry_Count), 64'(0));
        check("rst_complite", 64'(Xfer_complite), 64'(0));
        check("rst_fail", 64'(Xfer_Fail), 64'(0));
        rst = 0;
        step();

        clear_plans();
        start_xfer(1'b0, 32'h100, 32'd0);
        finish_xfer("t1_single_read");

        clear_plans();
        start_xfer(1'b0, 32'h100, 32'd2);
        finish_xfer("t2_multi_read");

        clear_plans();
        plan_crc = '{0, 1, 0, 0};
        start_xfer(1'b0, 32'h100, 32'd2);
        finish_xfer("t3_crc_retry");

        clear_plans();
        plan_resp = '{2, 2, 2};
        start_xfer(1'b0, 32'h40, 32'd0);
        finish_xfer("t4_timeouts");

        clear_plans();
        plan_resp = '{3};
        start_xfer(1'b1, 32'h800, 32'd1);
        finish_xfer("t5_write_status_err");

        clear_plans();
        plan_crc = '{0, 1};
        start_xfer(1'b0, 32'hFFFF_FFFF, 32'd2);
        finish_xfer("addr_wrap");

        clear_plans();
        plan_stop = '{2};
        start_xfer(1'b1, 32'h20, 32'd1);
        finish_xfer("stop_timeout");

        clear_plans();
        plan_crc = '{1, 1, 1};
        start_xfer(1'b1, 32'h300, 32'd3);
        finish_xfer("retry_exhausted");

        clear_plans();
        start_xfer(1'b0, 32'h200, 32'd2);
        n = 0;
        while (!(Get_DATA_En && resp_ok) && n < 200) begin
            step();
            n++;
        end
        check("t6_reached_data", 64'(n < 200), 64'(1));
        rst = 1;
        Xfer_Enable = 0;
        step();
        check("t6_enables_dropped",
              64'({Send_CMD_En, Get_CMD_En, Get_DATA_En, Put_DATA_En}), 64'(0));
        check("t6_cmd_id_cleared", 64'(CMD_ID), 64'(0));
        check("t6_block_count_cleared", 64'(BlockCount), 64'(0));
        rst = 0;
        repeat (3) step();
        check("t6_no_stop_after_rst", 64'(Send_CMD_En), 64'(0));
        clear_plans();
        start_xfer(1'b0, 32'h200, 32'd2);
        finish_xfer("t6_restart");

        for (int t = 0; t < 10; t++) begin
            clear_plans();
            for (int k = 0; k < 4; k++) begin
                r = $urandom_range(0, 99);
                plan_resp.push_back(r < 70 ? 0 : (r < 88 ? 1 : (r < 95 ? 3 : 2)));
            end
            for (int k = 0; k < 16; k++) plan_crc.push_back(int'($urandom_range(0, 99) < 15));
            for (int k = 0; k < 4; k++) plan_stop.push_back(int'($urandom_range(0, 99) < 5));
            start_xfer(1'($urandom), (t == 3) ? 32'hFFFF_FFFE : $urandom, $urandom_range(0, 4));
            finish_xfer($sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
